// File: rtl/vrased_pkg.sv
// Shared constants and types for the VRASED hardware security monitor.
// Region bounds are inclusive, unsigned 16-bit compares with no wrap-around.
package vrased_pkg;

    localparam logic [15:0] SMEM_BASE      = 16'hA000;
    localparam logic [15:0] SMEM_SIZE      = 16'h4000;
    localparam logic [15:0] LAST_SMEM_ADDR = SMEM_BASE + SMEM_SIZE - 16'd2;

    localparam logic [15:0] KMEM_BASE      = 16'h6A00;
    localparam logic [15:0] KMEM_SIZE      = 16'h001F;
    localparam logic [15:0] KMEM_END       = KMEM_BASE + KMEM_SIZE;

    localparam logic [15:0] SDATA_BASE     = 16'h0400;
    localparam logic [15:0] SDATA_SIZE     = 16'h0C00;
    localparam logic [15:0] SDATA_END      = SDATA_BASE + SDATA_SIZE - 16'd1;

    localparam logic [15:0] RESET_HANDLER  = 16'h0000;

    // One kill FSM per rule family; indices into the violation/kill vectors.
    localparam int MON_KEY  = 0;
    localparam int MON_XS   = 1;
    localparam int MON_ROM  = 2;
    localparam int MON_ATOM = 3;
    localparam int MON_DMA  = 4;
    localparam int N_MON    = 5;

    typedef enum logic {
        RUN  = 1'b0,
        KILL = 1'b1
    } mon_state_e;

    function automatic logic in_range(input logic [15:0] addr,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/vrased_kill_fsm.sv
// Per-monitor RUN/KILL state machine: a violation latches KILL until the CPU
// is back at the reset handler with no violation in that same cycle.
module vrased_kill_fsm
    import vrased_pkg::*;
(
    input  logic clk,
    input  logic clr_ram,
    input  logic violation,
    input  logic pc_is_reset,
    output logic kill
);

    mon_state_e state, state_next;

    always_ff @(posedge clk or posedge clr_ram) begin
        if (clr_ram) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (violation) state_next = KILL;
            KILL:    if (pc_is_reset && !violation) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    assign kill = (state == KILL);

endmodule

// File: rtl/vrased.sv
// VRASED monitor top: region decoders, previous-PC register and the per-rule
// kill FSMs whose states are OR-ed into the MCU reset request.
module vrased
    import vrased_pkg::*;
(
    input  logic        clk,
    input  logic        clr_ram,
    input  logic [15:0] pc,
    input  logic        data_en,
    input  logic        data_wr,
    input  logic [15:0] data_addr,
    input  logic        dma_en,
    input  logic [15:0] dma_addr,
    input  logic        irq,
    output logic        reset
);

    logic [15:0]      prev_pc;
    logic             in_smem, prev_in_smem;
    logic             data_in_kmem, data_in_sdata, data_in_smem;
    logic             dma_in_kmem, dma_in_sdata;
    logic [N_MON-1:0] violation;
    logic [N_MON-1:0] kill;

    always_ff @(posedge clk or posedge clr_ram) begin
        if (clr_ram) begin
            prev_pc <= RESET_HANDLER;
        end else begin
            prev_pc <= pc;
        end
    end

    assign in_smem       = in_range(pc,        SMEM_BASE,  LAST_SMEM_ADDR);
    assign prev_in_smem  = in_range(prev_pc,   SMEM_BASE,  LAST_SMEM_ADDR);
    assign data_in_kmem  = in_range(data_addr, KMEM_BASE,  KMEM_END);
    assign data_in_sdata = in_range(data_addr, SDATA_BASE, SDATA_END);
    assign data_in_smem  = in_range(data_addr, SMEM_BASE,  LAST_SMEM_ADDR);
    assign dma_in_kmem   = in_range(dma_addr,  KMEM_BASE,  KMEM_END);
    assign dma_in_sdata  = in_range(dma_addr,  SDATA_BASE, SDATA_END);

    assign violation[MON_KEY]  = data_en && data_in_kmem && !in_smem;

    // X_Stack is private to SW-Att, and SW-Att may write nowhere else.
    assign violation[MON_XS]   = (data_en && data_in_sdata && !in_smem) ||
                                 (in_smem && data_en && data_wr && !data_in_sdata);

    assign violation[MON_ROM]  = data_en && data_wr && data_in_smem;

    assign violation[MON_ATOM] = (!prev_in_smem && in_smem && (pc != SMEM_BASE)) ||
                                 (prev_in_smem && !in_smem && (prev_pc != LAST_SMEM_ADDR)) ||
                                 (irq && in_smem);

    assign violation[MON_DMA]  = dma_en && (dma_in_kmem || dma_in_sdata || in_smem);

    for (genvar i = 0; i < N_MON; i++) begin : g_mon
        vrased_kill_fsm u_kill_fsm (
            .clk         (clk),
            .clr_ram     (clr_ram),
            .violation   (violation[i]),
            .pc_is_reset (pc == RESET_HANDLER),
            .kill        (kill[i])
        );
    end

    assign reset = |kill;

endmodule

// File: tb/tb_vrased.sv
// Directed self-checking bench for the VRASED monitor; expected reset values
// are worked out by hand from the monitor rules for each step.
module tb_vrased;

    logic        clk = 1'b0;
    logic        clr_ram;
    logic [15:0] pc;
    logic        data_en;
    logic        data_wr;
    logic [15:0] data_addr;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic        irq;
    logic        reset;

    int checks = 0;
    int errors = 0;

    vrased dut (
        .clk       (clk),
        .clr_ram   (clr_ram),
        .pc        (pc),
        .data_en   (data_en),
        .data_wr   (data_wr),
        .data_addr (data_addr),
        .dma_en    (dma_en),
        .dma_addr  (dma_addr),
        .irq       (irq),
        .reset     (reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic expected);
        checks++;
        assert (reset === expected) else begin
            errors++;
            $error("FAIL %s: reset=%b expected %b", tag, reset, expected);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [15:0] new_pc);
        pc        = new_pc;
        data_en   = 1'b0;
        data_wr   = 1'b0;
        data_addr = 16'h0000;
        dma_en    = 1'b0;
        dma_addr  = 16'h0000;
        irq       = 1'b0;
    endtask

    logic [15:0] legal_walk [6] = '{16'hA000, 16'hDFFE, 16'h0000,
                                    16'hA000, 16'hDFFE, 16'h0000};

    initial begin
        clr_ram = 1'b1;
        idle(16'h0000);
        tick(); check("clr_c1", 1'b0);
        tick(); check("clr_c2", 1'b0);
        clr_ram = 1'b0;
        tick(); check("idle_c1", 1'b0);
        tick(); check("idle_c2", 1'b0);

        // X_Stack read from untrusted code
        data_en = 1'b1; data_addr = 16'h0440;
        tick(); check("xs_pulse", 1'b1);
        idle(16'h0000);
        tick(); check("xs_pulse_end", 1'b0);
        tick(); check("xs_quiet", 1'b0);

        // Key reads from untrusted code, including the inclusive end address
        data_en = 1'b1; data_addr = 16'h6A00;
        tick(); check("key_pulse", 1'b1);
        idle(16'h0000);
        tick(); check("key_pulse_end", 1'b0);
        data_en = 1'b1; data_addr = 16'h6A1F;
        tick(); check("key_last", 1'b1);
        idle(16'h0000);
        tick(); check("key_last_end", 1'b0);
        data_en = 1'b1; data_addr = 16'h6A20;
        tick(); check("key_past_end", 1'b0);
        data_addr = 16'h03FF;
        tick(); check("xs_below_base", 1'b0);

        // Key read from inside SW-Att, entered and left legally
        idle(16'hA000);
        tick(); check("enter_base", 1'b0);
        pc = 16'hA010; data_en = 1'b1; data_addr = 16'h6A00;
        tick(); check("key_in_smem", 1'b0);
        idle(16'hDFFE);
        tick(); check("walk_to_last", 1'b0);
        idle(16'h0000);
        tick(); check("exit_last", 1'b0);

        // Exit from the entry point instead of the last address
        idle(16'hA000);
        tick(); check("enter_again", 1'b0);
        idle(16'h0000);
        tick(); check("bad_exit", 1'b1);
        tick(); check("bad_exit_end", 1'b0);

        // Entry off the base; the forced exit violates again in the release cycle
        idle(16'hA002);
        tick(); check("bad_entry", 1'b1);
        idle(16'h0000);
        tick(); check("release_blocked", 1'b1);
        tick(); check("release_ok", 1'b0);

        for (int i = 0; i < 6; i++) begin
            idle(legal_walk[i]);
            tick(); check($sformatf("reentry_%0d", i), 1'b0);
        end

        // Interrupt while in SW-Att holds KILL until pc reaches 0
        idle(16'hA000);
        tick(); check("irq_pre", 1'b0);
        irq = 1'b1;
        tick(); check("irq_smem", 1'b1);
        idle(16'hDFFE);
        tick(); check("irq_hold", 1'b1);
        idle(16'h0000);
        tick(); check("irq_release", 1'b0);

        // DMA into key memory vs. unprotected memory
        dma_en = 1'b1; dma_addr = 16'h6A00;
        tick(); check("dma_key", 1'b1);
        idle(16'h0000);
        tick(); check("dma_key_end", 1'b0);
        dma_en = 1'b1; dma_addr = 16'h2000;
        tick(); check("dma_ok", 1'b0);

        // SW-Att write to ROM
        idle(16'hA000);
        tick(); check("rom_pre", 1'b0);
        data_en = 1'b1; data_wr = 1'b1; data_addr = 16'hB000;
        tick(); check("rom_write", 1'b1);
        idle(16'hDFFE);
        tick(); check("rom_hold", 1'b1);
        idle(16'h0000);
        tick(); check("rom_release", 1'b0);

        // KILL holds away from the reset handler
        idle(16'h1234);
        data_en = 1'b1; data_addr = 16'h0440;
        tick(); check("hold_set", 1'b1);
        idle(16'h1234);
        tick(); check("hold_c1", 1'b1);
        tick(); check("hold_c2", 1'b1);
        idle(16'h0000);
        tick(); check("hold_release", 1'b0);

        // clr_ram clears a held KILL asynchronously
        idle(16'h1234);
        data_en = 1'b1; data_addr = 16'h0440;
        tick(); check("clr_set", 1'b1);
        idle(16'h1234);
        tick(); check("clr_hold", 1'b1);
        clr_ram = 1'b1;
        #1; check("clr_async", 1'b0);
        tick(); check("clr_stays", 1'b0);
        clr_ram = 1'b0;
        tick(); check("after_clr", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
